// File: rtl/nyq_frame_ctrl.sv
// nyq_frame_ctrl: captures an 8-sample frame into a register file, then drains it in arrival order.
// Optional sticky overrun flag is built only when NYQ_FRAME_CTRL_OVERRUN_EN is defined.
//
// Ports:
//   Clk_CI, Rst_RI          clock, async active-high reset
//   Start_SI                arm a frame capture (IDLE only)
//   Samp_DI, SampValid_SI   upstream sample and valid
//   SampReady_SO, WrEn_SO   ready (FILL) and accept strobe
//   WrIdx_DO                current write index (7 down to 0)
//   Out_DO, OutValid_SO     downstream sample and valid
//   OutReady_SI             downstream ready
//   Busy_SO, Done_SO        FILL/DRAIN active, end-of-frame pulse
//   Overrun_SO              sticky sample-offered-outside-FILL flag
module nyq_frame_ctrl #(
   parameter int DATA_W = 8
) (
   input  logic              Clk_CI,
   input  logic              Rst_RI,
   input  logic              Start_SI,
   input  logic [DATA_W-1:0] Samp_DI,
   input  logic              SampValid_SI,
   output logic              SampReady_SO,
   output logic              WrEn_SO,
   output logic [2:0]        WrIdx_DO,
   output logic [DATA_W-1:0] Out_DO,
   output logic              OutValid_SO,
   input  logic              OutReady_SI,
   output logic              Busy_SO,
   output logic              Done_SO,
   output logic              Overrun_SO
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        wr_idx_q, rd_idx_q;
   logic [DATA_W-1:0] mem_q [8];
   logic              done_q;
   logic              accept, xfer;

   assign accept = SampValid_SI && SampReady_SO;
   assign xfer   = OutValid_SO && OutReady_SI;

   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (Start_SI) state_d = FILL;
         FILL:    if (accept && wr_idx_q == 3'd0) state_d = DRAIN;
         DRAIN:   if (xfer && rd_idx_q == 3'd0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs come from the state register only, so no
   // input-to-output path exists apart from the write strobe.
   always_comb begin
      SampReady_SO = 1'b0;
      OutValid_SO  = 1'b0;
      Busy_SO      = 1'b0;
      unique case (state_q)
         FILL: begin
            SampReady_SO = 1'b1;
            Busy_SO      = 1'b1;
         end
         DRAIN: begin
            OutValid_SO = 1'b1;
            Busy_SO     = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         wr_idx_q <= 3'd7;
         rd_idx_q <= 3'd7;
         done_q   <= 1'b0;
         for (int i = 0; i < 8; i++) mem_q[i] <= '0;
      end else begin
         done_q <= xfer && (rd_idx_q == 3'd0);
         if (state_q == IDLE) begin
            wr_idx_q <= 3'd7;
            rd_idx_q <= 3'd7;
         end
         // Down-counting index wraps 0 -> 7 naturally on the last accept.
         if (accept) begin
            mem_q[wr_idx_q] <= Samp_DI;
            wr_idx_q        <= wr_idx_q - 3'd1;
         end
         if (xfer) rd_idx_q <= rd_idx_q - 3'd1;
      end
   end

   assign WrEn_SO  = accept;
   assign WrIdx_DO = wr_idx_q;
   assign Out_DO   = mem_q[rd_idx_q];
   assign Done_SO  = done_q;

`ifdef NYQ_FRAME_CTRL_OVERRUN_EN
   logic ovr_q;

   // Clear has priority when a start and a stray sample coincide in IDLE.
   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI)                             ovr_q <= 1'b0;
      else if (state_q == IDLE && Start_SI)   ovr_q <= 1'b0;
      else if (SampValid_SI && state_q != FILL) ovr_q <= 1'b1;
   end

   assign Overrun_SO = ovr_q;
`else
   assign Overrun_SO = 1'b0;
`endif

endmodule

// File: tb/tb_nyq_frame_ctrl.sv
// tb_nyq_frame_ctrl: directed frames with a drain-data scoreboard.
// Stimulus pushes expected samples; a negedge monitor pops on each transfer.
module tb_nyq_frame_ctrl;

   logic       Clk_CI = 1'b0;
   logic       Rst_RI = 1'b1;
   logic       Start_SI = 1'b0;
   logic [7:0] Samp_DI = 8'h00;
   logic       SampValid_SI = 1'b0;
   logic       SampReady_SO;
   logic       WrEn_SO;
   logic [2:0] WrIdx_DO;
   logic [7:0] Out_DO;
   logic       OutValid_SO;
   logic       OutReady_SI = 1'b0;
   logic       Busy_SO;
   logic       Done_SO;
   logic       Overrun_SO;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

`ifdef NYQ_FRAME_CTRL_OVERRUN_EN
   localparam logic OVR_EN = 1'b1;
`else
   localparam logic OVR_EN = 1'b0;
`endif

   nyq_frame_ctrl #(.DATA_W(8)) dut (
      .Clk_CI       (Clk_CI),
      .Rst_RI       (Rst_RI),
      .Start_SI     (Start_SI),
      .Samp_DI      (Samp_DI),
      .SampValid_SI (SampValid_SI),
      .SampReady_SO (SampReady_SO),
      .WrEn_SO      (WrEn_SO),
      .WrIdx_DO     (WrIdx_DO),
      .Out_DO       (Out_DO),
      .OutValid_SO  (OutValid_SO),
      .OutReady_SI  (OutReady_SI),
      .Busy_SO      (Busy_SO),
      .Done_SO      (Done_SO),
      .Overrun_SO   (Overrun_SO)
   );

   always #5 Clk_CI = ~Clk_CI;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic tick();
      @(posedge Clk_CI);
      #1;
   endtask

   always @(negedge Clk_CI) begin
      if (!Rst_RI && OutValid_SO && OutReady_SI) begin
         if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
         else chk("out_data", {24'd0, Out_DO}, {24'd0, exp_q.pop_front()});
      end
   end

   // One full frame. Starts in the caller's current cycle (may be a
   // Done cycle) and ends in the cycle where Done_SO is high.
   task automatic run_frame(input logic [7:0] base, input bit gaps,
                            input bit bp, input bit spulse);
      int i, k, t, bpc;
      logic v;
      for (int j = 0; j < 8; j++) exp_q.push_back(base + 8'(j));
      Start_SI = 1'b1;
      // A stray valid alongside start is not accepted in IDLE.
      SampValid_SI = gaps;
      Samp_DI = 8'hEE;
      #1;
      chk("wren_idle", WrEn_SO, 0);
      tick();
      Start_SI = 1'b0;
      SampValid_SI = 1'b0;
      chk("fill_ready", SampReady_SO, 1);
      chk("fill_busy", Busy_SO, 1);
      chk("fill_done_low", Done_SO, 0);
      chk("ovr_cleared", Overrun_SO, 0);
      i = 0;
      k = 0;
      while (i < 8 && k < 40) begin
         v = gaps ? ~k[0] : 1'b1;
         SampValid_SI = v;
         Samp_DI = v ? base + 8'(i) : 8'hEE;
         Start_SI = spulse && (k == 2);
         #1;
         chk("wr_idx", {29'd0, WrIdx_DO}, 32'(7 - i));
         chk("wr_en", WrEn_SO, v);
         chk("fill_no_out", OutValid_SO, 0);
         tick();
         if (v) i++;
         k++;
      end
      Start_SI = 1'b0;
      SampValid_SI = 1'b0;
      chk("drain_valid", OutValid_SO, 1);
      chk("drain_not_ready", SampReady_SO, 0);
      chk("wr_idx_wrap", {29'd0, WrIdx_DO}, 7);
      t = 0;
      k = 0;
      bpc = 0;
      while (t < 8 && k < 40) begin
         chk("out_valid", OutValid_SO, 1);
         if (bp && t == 3 && bpc < 5) begin
            OutReady_SI = 1'b0;
            chk("bp_hold", {24'd0, Out_DO}, {24'd0, base + 8'd3});
            bpc++;
         end else begin
            OutReady_SI = 1'b1;
         end
         chk("done_low", Done_SO, 0);
         tick();
         if (OutReady_SI) t++;
         k++;
      end
      OutReady_SI = 1'b0;
      chk("done_pulse", Done_SO, 1);
      chk("idle_no_valid", OutValid_SO, 0);
      chk("idle_busy", Busy_SO, 0);
      chk("sb_drained", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #23;
      chk("rst_wr_idx", {29'd0, WrIdx_DO}, 7);
      chk("rst_ready", SampReady_SO, 0);
      chk("rst_wren", WrEn_SO, 0);
      chk("rst_valid", OutValid_SO, 0);
      chk("rst_busy", Busy_SO, 0);
      chk("rst_done", Done_SO, 0);
      chk("rst_ovr", Overrun_SO, 0);
      chk("rst_out", {24'd0, Out_DO}, 0);
      Rst_RI = 1'b0;
      tick();
      tick();

      run_frame(8'h10, 0, 0, 0);
      tick();
      chk("done_one_cycle", Done_SO, 0);

      // Gapped capture with an ignored mid-fill start, then back-to-back
      // frames where each new start lands in the Done cycle.
      run_frame(8'h20, 1, 0, 1);
      run_frame(8'h30, 0, 1, 0);
      run_frame(8'h38, 0, 0, 0);
      tick();

      // Stray valid in IDLE sets the overrun flag (when built).
      SampValid_SI = 1'b1;
      Samp_DI = 8'h99;
      tick();
      SampValid_SI = 1'b0;
      chk("ovr_set", Overrun_SO, OVR_EN);
      tick();
      chk("ovr_sticky", Overrun_SO, OVR_EN);
      run_frame(8'h40, 0, 0, 0);
      tick();

      // Abandon a frame with an async reset at WrIdx=3.
      Start_SI = 1'b1;
      tick();
      Start_SI = 1'b0;
      for (int j = 0; j < 4; j++) begin
         SampValid_SI = 1'b1;
         Samp_DI = 8'hA0 + 8'(j);
         tick();
      end
      SampValid_SI = 1'b0;
      chk("pre_rst_idx", {29'd0, WrIdx_DO}, 3);
      #2 Rst_RI = 1'b1;
      #1;
      chk("arst_idx", {29'd0, WrIdx_DO}, 7);
      chk("arst_ready", SampReady_SO, 0);
      chk("arst_busy", Busy_SO, 0);
      chk("arst_valid", OutValid_SO, 0);
      chk("arst_out", {24'd0, Out_DO}, 0);
      tick();
      #2 Rst_RI = 1'b0;
      for (int j = 0; j < 10; j++) begin
         tick();
         chk("no_partial_drain", OutValid_SO, 0);
      end

      run_frame(8'h50, 1, 1, 0);
      tick();
      tick();
      chk("sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
